// File: rtl/adc_sample_player.sv
// adc_sample_player: replays a preloaded signed multi-channel table at a programmable rate over valid/ready.
// Define PLAYER_GAIN_EN to add the registered per-channel shift/saturate stage (gain_shl, sat).
module adc_sample_player #(
  parameter int DATA_W = 14,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int DIV_W  = 16
) (
  input  logic                     CLK_IN,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W*NUM_CH-1:0] wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W-1:0]        last_addr,
  input  logic [DIV_W-1:0]         rate_div,
`ifdef PLAYER_GAIN_EN
  input  logic [2:0]               gain_shl,
  output logic                     sat,
`endif
  output logic [DATA_W*NUM_CH-1:0] sample_out,
  output logic                     sample_valid,
  input  logic                     sample_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);
  localparam int W = DATA_W*NUM_CH;
  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, FIN} state_t;
  state_t state_q, state_d;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_q;
  logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d;
  logic [DIV_W-1:0] div_q, div_d, rate_q, rate_d;
  logic loop_q, loop_d, pend_q, pend_d, ovr_q, ovr_d, rv_q, rv_d;
  logic acc, adv, free, drained, strobe, fetch;
  logic [1:0] dem, rem;

  assign acc  = sample_valid && sample_ready;
  assign free = !rv_q || adv;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign overrun = ovr_q;

  always_ff @(posedge CLK_IN) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // The read register doubles as the first output slot, so a fetch presents next cycle.
  always_ff @(posedge CLK_IN) begin
    if (RESET) rd_q <= '0;
    else if (fetch) rd_q <= mem[addr_q];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    last_d  = last_q;
    rate_d  = rate_q;
    loop_d  = loop_q;
    div_d   = div_q;
    pend_d  = pend_q;
    ovr_d   = ovr_q;
    fetch   = 1'b0;
    strobe  = state_q == RUN && div_q == rate_q;
    dem     = {1'b0, pend_q} + {1'b0, strobe};
    rem     = dem;
    case (state_q)
      IDLE: if (start) begin
        state_d = PRIME;
        loop_d  = loop_en;
        last_d  = last_addr;
        rate_d  = rate_div;
        addr_d  = '0;
        div_d   = '0;
        pend_d  = 1'b0;
        ovr_d   = 1'b0;
      end
      PRIME: begin
        state_d = stop ? DRAIN : RUN;
        fetch   = !stop;
      end
      RUN: begin
        fetch   = !stop && dem != 2'd0 && free;
        rem     = dem - {1'b0, fetch};
        div_d   = strobe ? '0 : div_q + DIV_W'(1);
        pend_d  = |rem;
        ovr_d   = ovr_q || rem[1];
        state_d = stop ? DRAIN : RUN;
      end
      DRAIN: state_d = drained ? FIN : DRAIN;
      default: state_d = IDLE;
    endcase
    if (fetch) begin
      addr_d = addr_q == last_q ? '0 : addr_q + ADDR_W'(1);
      if (addr_q == last_q && !loop_q) state_d = DRAIN;
    end
    rv_d = fetch || (rv_q && !adv);
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      rate_q  <= '0;
      loop_q  <= 1'b0;
      div_q   <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      rate_q  <= rate_d;
      loop_q  <= loop_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      rv_q    <= rv_d;
    end
  end

`ifdef PLAYER_GAIN_EN
  logic [W-1:0] out_q, out_d, gained;
  logic ov_q, ov_d, sat_q, sat_d, clip, fits;
  logic [2:0] gain_q, gain_d;
  logic [DATA_W+6:0] wide;

  assign adv          = rv_q && (!ov_q || acc);
  assign drained      = !rv_q && (!ov_q || acc);
  assign sample_out   = out_q;
  assign sample_valid = ov_q;
  assign sat          = sat_q;

  always_comb begin
    gained = '0;
    clip   = 1'b0;
    wide   = '0;
    fits   = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      wide = {{7{rd_q[i*DATA_W+DATA_W-1]}}, rd_q[i*DATA_W +: DATA_W]} << gain_q;
      fits = &wide[DATA_W+6:DATA_W-1] || !(|wide[DATA_W+6:DATA_W-1]);
      gained[i*DATA_W +: DATA_W] = fits ? wide[DATA_W-1:0] : {wide[DATA_W+6], {(DATA_W-1){!wide[DATA_W+6]}}};
      clip = clip || !fits;
    end
    out_d  = adv ? gained : out_q;
    ov_d   = adv || (ov_q && !acc);
    sat_d  = state_q == IDLE && start ? 1'b0 : sat_q || (adv && clip);
    gain_d = state_q == IDLE && start ? gain_shl : gain_q;
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      out_q  <= '0;
      ov_q   <= 1'b0;
      sat_q  <= 1'b0;
      gain_q <= '0;
    end else begin
      out_q  <= out_d;
      ov_q   <= ov_d;
      sat_q  <= sat_d;
      gain_q <= gain_d;
    end
  end
`else
  assign adv          = acc;
  assign drained      = !rv_q || acc;
  assign sample_out   = rd_q;
  assign sample_valid = rv_q;
`endif
endmodule

// File: tb/tb_adc_sample_player.sv
// tb_adc_sample_player: randomized and directed playback runs scored against a table-index reference model.
module tb_adc_sample_player;
  localparam int DW = 14, NC = 2, DEPTH = 1024, AW = 10, DVW = 16, WW = DW*NC;
`ifdef PLAYER_GAIN_EN
  localparam int LAT = 3;
  logic [2:0] gain_shl;
  logic sat;
`else
  localparam int LAT = 2;
`endif
  logic CLK_IN = 1'b0;
  logic RESET, wr_en, start, stop, loop_en, sample_ready, sample_valid, busy, done, overrun;
  logic [AW-1:0] wr_addr, last_addr;
  logic [WW-1:0] wr_data, sample_out;
  logic [DVW-1:0] rate_div;

  adc_sample_player #(.DATA_W(DW), .NUM_CH(NC), .DEPTH(DEPTH), .ADDR_W(AW), .DIV_W(DVW)) dut (
    .CLK_IN(CLK_IN), .RESET(RESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop_en(loop_en), .last_addr(last_addr), .rate_div(rate_div),
`ifdef PLAYER_GAIN_EN
    .gain_shl(gain_shl), .sat(sat),
`endif
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 CLK_IN = ~CLK_IN;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int n_acc, n_done, first_cyc, done_cyc, last_cyc, start_cyc, cur_last, cur_rate, cur_gain = 0;
  bit mon_en = 0, hold = 0, chk_rate = 0, rnd_ready = 0;
  logic [WW-1:0] hold_w, new3;
  logic [WW-1:0] tbl [DEPTH];
  logic [WW-1:0] acc_log [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input int a, input int b);
    logic [WW-1:0] r;
    r = '0;
    r[DW-1:0] = a[DW-1:0];
    r[2*DW-1:DW] = b[DW-1:0];
    return r;
  endfunction

  // k-th accepted word: table entry k mod (last+1), each channel scaled by 2^gain and clamped.
  function automatic logic [WW-1:0] exp_word(input int k);
    logic [WW-1:0] w, r;
    int v;
    w = tbl[k % (cur_last + 1)];
    r = '0;
    for (int c = 0; c < NC; c++) begin
      v = $signed(w[c*DW +: DW]) * (1 << cur_gain);
      if (v > (1 << (DW-1)) - 1) v = (1 << (DW-1)) - 1;
      if (v < -(1 << (DW-1))) v = -(1 << (DW-1));
      r[c*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(negedge CLK_IN);
    if (mon_en) begin
      if (hold) begin
        check("hold_word", sample_out, hold_w);
        check("hold_valid", sample_valid, 1);
      end
      if (sample_valid && sample_ready) begin
        if (n_acc == 0) first_cyc = cyc;
        else if (chk_rate) check("rate", cyc - last_cyc, cur_rate + 1);
        check("word", sample_out, exp_word(n_acc));
        acc_log.push_back(sample_out);
        n_acc++;
        last_cyc = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
      hold = sample_valid && !sample_ready;
      hold_w = sample_out;
    end else hold = 0;
    @(posedge CLK_IN);
    #1;
    cyc++;
    if (rnd_ready) sample_ready = $urandom_range(0, 3) != 0;
  endtask

  task automatic write_word(input int a, input logic [WW-1:0] d);
    wr_en = 1;
    wr_addr = a[AW-1:0];
    wr_data = d;
    tbl[a] = d;
    tick();
    wr_en = 0;
  endtask

  task automatic play(input int last, input bit lp, input int rate, input int g);
    n_acc = 0;
    n_done = 0;
    acc_log.delete();
    cur_last = last;
    cur_rate = rate;
    cur_gain = g;
    chk_rate = !rnd_ready;
    mon_en = 1;
    last_addr = last[AW-1:0];
    loop_en = lp;
    rate_div = rate[DVW-1:0];
`ifdef PLAYER_GAIN_EN
    gain_shl = g[2:0];
`endif
    start = 1;
    start_cyc = cyc;
    tick();
    start = 0;
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 3000 && n_acc < n; i++) tick();
    if (n_acc < n) check("acc_timeout", n_acc, n);
  endtask

  task automatic do_stop();
    stop = 1;
    tick();
    stop = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && n_done == 0; i++) tick();
    check("idle_after_done", busy, 0);
    tick();
    tick();
    check("done_once", n_done, 1);
  endtask

  initial begin
    {RESET, wr_en, start, stop, loop_en, sample_ready} = '0;
    wr_addr = '0;
    wr_data = '0;
    last_addr = '0;
    rate_div = '0;
`ifdef PLAYER_GAIN_EN
    gain_shl = '0;
`endif
    RESET = 1;
    tick();
    tick();
    check("rst_out", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovr", overrun, 0);
    RESET = 0;
    sample_ready = 1;
    for (int i = 0; i < 8; i++) write_word(i, mk(100*i, -100*i));

    play(7, 0, 0, 0);
    wait_done();
    check("t1_first", first_cyc - start_cyc, LAT);
    check("t1_done", done_cyc - start_cyc, LAT + 8);
    check("t1_count", n_acc, 8);
    check("t1_ovr", overrun, 0);
`ifdef PLAYER_GAIN_EN
    check("t1_sat", sat, 0);
`endif

    play(7, 1, 3, 0);
    wait_acc(20);
    do_stop();
    wait_done();
    check("t2_count", n_acc, 20);
    check("t2_last", acc_log.size() > 19 ? acc_log[19] : '0, tbl[3]);
    check("t2_ovr", overrun, 0);

    play(7, 0, 1, 0);
    chk_rate = 0;
    wait_acc(2);
    sample_ready = 0;
    repeat (6) tick();
    sample_ready = 1;
    wait_done();
    check("t3_count", n_acc, 8);
    check("t3_ovr", overrun, 1);

    play(7, 1, 1, 0);
    wait_acc(5);
    RESET = 1;
    mon_en = 0;
    tick();
    check("t4_out", sample_out, 0);
    check("t4_valid", sample_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_ovr", overrun, 0);
    RESET = 0;
    tick();
    play(7, 0, 0, 0);
    wait_done();
    check("t4_count", n_acc, 8);
    check("t4_first", acc_log.size() > 0 ? acc_log[0] : '1, tbl[0]);

    play(7, 1, 1, 0);
    wait_acc(9);
    new3 = mk(14'h1FFF, 14'h2000);
    write_word(3, new3);
    wait_acc(20);
    do_stop();
    wait_done();
    check("t5_new3", acc_log.size() > 11 ? acc_log[11] : '0, new3);
    check("t5_old3", acc_log.size() > 3 ? acc_log[3] : '0, mk(300, -300));

    rnd_ready = 1;
    for (int it = 0; it < 10; it++) begin
      int last, rate, g;
      last = it == 0 ? 0 : $urandom_range(0, 15);
      rate = $urandom_range(0, 3);
      g = 0;
`ifdef PLAYER_GAIN_EN
      g = $urandom_range(0, 7);
`endif
      for (int a = 0; a <= last; a++) write_word(a, WW'($urandom));
      play(last, 0, rate, g);
      wait_done();
      check("rnd_count", n_acc, last + 1);
    end
    rnd_ready = 0;
    sample_ready = 1;

`ifdef PLAYER_GAIN_EN
    write_word(0, mk(3000, -100));
    play(0, 0, 0, 2);
    wait_done();
    check("gain_first", first_cyc - start_cyc, 3);
    check("gain_word", acc_log.size() > 0 ? acc_log[0] : '0, mk(8191, -400));
    check("gain_sat", sat, 1);
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
